// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// control FSM states, operand-forward select codes and the default load encoding.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } hz_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [1:0] RESULT_LOAD_DEF = 2'b01;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding select for one ALU source.
// The youngest producer (M) wins over W; register x0 is never forwarded.
module hazard_fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);

    // Priority select between the M and W results
    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            fwd = FWD_M;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            fwd = FWD_W;
        end else begin
            fwd = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use and redirect bubbles, memory-wait
// stalls with a sticky timeout. Optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int         WAIT_W      = 4,
    parameter logic [1:0] RESULT_LOAD = RESULT_LOAD_DEF
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic [1:0] ResultSrcE,
    input  logic       PCSrcE,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       TimeoutErr
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt
`endif
);

    localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0] WAIT_MAX  = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_MAX - WAIT_ONE;

    hz_state_t         state_r;
    hz_state_t         state_next_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_next_s;
    logic              timeout_r;
    logic              mem_pending_s;
    logic              mem_stall_s;
    logic              load_use_s;
    logic              redirect_s;

    hazard_fwd_unit u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .fwd         (ForwardAE)
    );

    hazard_fwd_unit u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .fwd         (ForwardBE)
    );

    assign mem_pending_s = MemReqM && !MemReadyM;
    assign load_use_s    = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                           ((RdE == Rs1D) || (RdE == Rs2D));

    // Next state; the timeout fires on the edge where the counter reaches its maximum
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        case (state_r)
            RUN: begin
                if (mem_pending_s) begin
                    state_next_s    = MEM_WAIT;
                    wait_cnt_next_s = {WAIT_W{1'b0}};
                end else begin
                    state_next_s    = RUN;
                end
            end
            MEM_WAIT: begin
                if (!mem_pending_s) begin
                    state_next_s    = RUN;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_next_s    = ERR;
                    wait_cnt_next_s = WAIT_MAX;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + WAIT_ONE;
                end
            end
            ERR:     state_next_s = ERR;
            default: state_next_s = RUN;
        endcase
    end

    // State, wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r    <= RUN;
            wait_cnt_r <= {WAIT_W{1'b0}};
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
            timeout_r  <= timeout_r | (state_next_s == ERR);
        end
    end

    assign TimeoutErr = timeout_r;

    // Stall/flush outputs: ERR > memory stall > redirect > load-use
    always_comb begin
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        StallM      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        FlushW      = 1'b0;
        mem_stall_s = 1'b0;
        redirect_s  = 1'b0;
        if (state_r == ERR) begin
            {StallF, StallD, StallE, StallM} = 4'b1111;
        end else if (mem_pending_s) begin
            mem_stall_s = 1'b1;
            {StallF, StallD, StallE, StallM} = 4'b1111;
            FlushW      = 1'b1;
        end else if (PCSrcE) begin
            redirect_s  = 1'b1;
            FlushD      = 1'b1;
            FlushE      = 1'b1;
        end else if (load_use_s) begin
            StallF      = 1'b1;
            StallD      = 1'b1;
            FlushE      = 1'b1;
        end else begin
            StallF      = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Free-running event counters, wrapping at 2^32
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (StallF) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (redirect_s) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end
        end
    end

    assign StallCnt = stall_cnt_r;
    assign FlushCnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a streak-counting reference model. Builds with or without HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;

    localparam int WAIT_W       = 4;
    localparam int TIMEOUT_CYCS = 1 << WAIT_W;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, MemReqM, MemReadyM;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, TimeoutErr;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] StallCnt, FlushCnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: stuck flag, length of the current memory-wait streak, event counts
    bit          m_err;
    int          m_streak;
    logic [31:0] m_stall_cnt;
    logic [31:0] m_flush_cnt;

    hazard_ctrl #(.WAIT_W(WAIT_W), .RESULT_LOAD(2'b01)) dut (
        .clk(clk), .n_rst(n_rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .TimeoutErr(TimeoutErr)
`ifdef HAZARD_PERF_CNT_EN
        , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 5'd0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE,TimeoutErr}
    function automatic logic [11:0] expect_outs();
        bit mem, lu, pc;
        logic [6:0] sf;
        mem = !m_err && MemReqM && !MemReadyM;
        pc  = !m_err && !mem && PCSrcE;
        lu  = !m_err && !mem && !PCSrcE && ResultSrcE == 2'b01 && RdE != 5'd0 &&
              (RdE == Rs1D || RdE == Rs2D);
        if (m_err)    sf = 7'b1111_000;
        else if (mem) sf = 7'b1111_001;
        else if (pc)  sf = 7'b0000_110;
        else if (lu)  sf = 7'b1100_010;
        else          sf = 7'b0000_000;
        return {sf, ref_fwd(Rs1E), ref_fwd(Rs2E), m_err};
    endfunction

    function automatic logic [11:0] dut_outs();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                ForwardAE, ForwardBE, TimeoutErr};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM} = '0;
        ResultSrcE = 2'b00;
    endtask

    // One clock: check at negedge, advance the model at posedge, return at posedge+1
    task automatic tick(input string tag);
        logic [11:0] e;
        @(negedge clk);
        e = expect_outs();
        chk(tag, {20'd0, dut_outs()}, {20'd0, e});
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, "_stallcnt"}, StallCnt, m_stall_cnt);
        chk({tag, "_flushcnt"}, FlushCnt, m_flush_cnt);
`endif
        @(posedge clk);
        if (e[11]) m_stall_cnt = m_stall_cnt + 32'd1;
        if (e[7])  m_flush_cnt = m_flush_cnt + 32'd1;
        if (!m_err) begin
            if (MemReqM && !MemReadyM) begin
                m_streak++;
                if (m_streak == TIMEOUT_CYCS) m_err = 1'b1;
            end else begin
                m_streak = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        n_rst = 1'b0;
        m_err = 1'b0; m_streak = 0; m_stall_cnt = 32'd0; m_flush_cnt = 32'd0;
        #2;
        chk("rst_timeout", {31'd0, TimeoutErr}, 32'd0);
        chk("rst_outs", {20'd0, dut_outs()}, 32'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    initial begin
        clear_inputs();
        n_rst = 1'b1;
        #1;
        do_reset();

        // Forwarding: M beats W, x0 in M falls back to W
        RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5;
        #1 chk("fwd_m_prio", {30'd0, ForwardAE}, 32'd2);
        tick("fwd_m");
        RdM = 5'd0;
        #1 chk("fwd_w", {30'd0, ForwardAE}, 32'd1);
        tick("fwd_w");
        Rs2E = 5'd5;
        tick("fwd_b");
        clear_inputs();

        // Load-use for exactly one cycle
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        #1 chk("ldu_on", {29'd0, StallF, StallD, FlushE}, 32'd7);
        tick("ldu_on");
        RdE = 5'd0;
        #1 chk("ldu_off", {29'd0, StallF, StallD, FlushE}, 32'd0);
        tick("ldu_off");

        // Redirect suppresses load-use
        RdE = 5'd7; PCSrcE = 1'b1;
        #1 chk("redir_ldu", {28'd0, FlushD, FlushE, StallF, StallD}, 32'hC);
        tick("redir_ldu");
        clear_inputs();

        // Three wait cycles then ready; redirect/load-use ignored while stalled
        MemReqM = 1'b1; PCSrcE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3;
        for (int i = 0; i < 3; i++) begin
            #1 chk("memstall", {27'd0, StallF, StallD, StallE, StallM, FlushW}, 32'h1F);
            tick("memstall");
        end
        MemReadyM = 1'b1; PCSrcE = 1'b0; ResultSrcE = 2'b00;
        #1 chk("mem_ready", {27'd0, StallF, StallD, StallE, StallM, FlushW}, 32'd0);
        tick("mem_ready");
        MemReqM = 1'b0; MemReadyM = 1'b0;
        tick("mem_after");
        MemReqM = 1'b1;
        tick("mem_again");
        clear_inputs();
        tick("mem_idle");

        // Timeout: ERR visible from the 17th consecutive stall cycle (index 16)
        do_reset();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1 chk("timeout_seq", {31'd0, TimeoutErr}, (i >= TIMEOUT_CYCS) ? 32'd1 : 32'd0);
            tick("timeout");
        end
        MemReqM = 1'b0;
        tick("err_hold");
        do_reset();
        MemReqM = 1'b1;
        tick("post_err");
        tick("post_err2");

`ifdef HAZARD_PERF_CNT_EN
        do_reset();
        MemReqM = 1'b1;
        repeat (4) tick("perf_stall");
        MemReqM = 1'b0; PCSrcE = 1'b1;
        repeat (2) tick("perf_redir");
        PCSrcE = 1'b0;
        chk("perf_stallcnt4", StallCnt, 32'd4);
        chk("perf_flushcnt2", FlushCnt, 32'd2);
`endif

        // Random traffic with occasional resets
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE     = ($urandom_range(0, 3) == 0);
            MemReqM    = 1'($urandom_range(0, 1));
            MemReadyM  = ($urandom_range(0, 2) == 0);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter WAIT_W, default 4, width of the memory-wait timeout counter.
REQ-002 Parameter RESULT_LOAD, default 2'b01, ResultSrc encoding that marks a load.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 n_rst  input  1  asynchronous active-low reset.
REQ-005 Rs1D, Rs2D  input  5 each  source registers in decode.
REQ-006 Rs1E, Rs2E, RdE  input  5 each  source and destination registers in execute.
REQ-007 RdM, RdW  input  5 each  destination registers in memory and writeback.
REQ-008 RegWriteM, RegWriteW  input  1 each  register-write enables of memory and writeback.
REQ-009 ResultSrcE  input  2  result select of execute.
REQ-010 PCSrcE  input  1  control-flow redirect resolved in execute.
REQ-011 MemReqM, MemReadyM  input  1 each  data-memory request and ready.
REQ-012 StallF, StallD, StallE, StallM  output  1 each  hold the corresponding pipeline register.
REQ-013 FlushD, FlushE, FlushW  output  1 each  load a bubble into D, E or W.
REQ-014 ForwardAE, ForwardBE  output  2 each  ALU operand select: 00 register file, 01 W result, 10 M result.
REQ-015 TimeoutErr  output  1  sticky memory-timeout flag.

Function
REQ-016 Forwarding SHALL be combinational: ForwardAE = 10 if RegWriteM, RdM!=0, RdM==Rs1E; else 01 if RegWriteW, RdW!=0, RdW==Rs1E; else 00; ForwardBE likewise with Rs2E.
REQ-017 M forwarding SHALL take priority over W when both match.
REQ-018 FSM states SHALL be RUN, MEM_WAIT, ERR.
REQ-019 RUN -> MEM_WAIT when MemReqM=1 and MemReadyM=0; MEM_WAIT -> RUN on the edge where MemReadyM=1; MEM_WAIT -> ERR when the wait counter reaches 2^WAIT_W-1 with MemReadyM=0; ERR exits only by reset.
REQ-020 Wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle without wrap.
REQ-021 Memory stall (MemReqM & !MemReadyM in RUN or MEM_WAIT) SHALL assert StallF, StallD, StallE, StallM and FlushW in the same cycle, with FlushD=FlushE=0.
REQ-022 Ready SHALL release all stalls combinationally in the cycle MemReadyM=1 (zero added latency).
REQ-023 Load-use hazard (ResultSrcE==RESULT_LOAD, RdE!=0, RdE==Rs1D or Rs2D) with no memory stall SHALL assert StallF, StallD, FlushE for exactly that cycle.
REQ-024 PCSrcE=1 with no memory stall SHALL assert FlushD and FlushE, and SHALL suppress the load-use stall in that cycle.
REQ-025 During a memory stall PCSrcE and load-use SHALL be ignored; they are re-evaluated once E is released.
REQ-026 In ERR all four stalls SHALL be 1, all flushes 0, TimeoutErr 1.
REQ-027 Priority: ERR > memory stall > redirect > load-use.

Reset
REQ-028 n_rst low SHALL asynchronously force state RUN, wait counter 0, TimeoutErr 0, perf counters 0.
REQ-029 Reset mid-MEM_WAIT or in ERR SHALL return to RUN; outputs then follow the inputs combinationally.

Configuration
REQ-030 With HAZARD_PERF_CNT_EN defined, outputs StallCnt and FlushCnt (32 bits each) SHALL exist: StallCnt +1 per cycle StallF=1, FlushCnt +1 per cycle FlushE=1 due to PCSrcE; both wrap at 2^32.
REQ-031 Without HAZARD_PERF_CNT_EN both ports and counters SHALL be absent; other behaviour unchanged.

Structure
REQ-032 Package hazard_pkg SHALL hold the state enum, forward-select constants FWD_RF/FWD_W/FWD_M and the RESULT_LOAD default.
REQ-033 Forwarding logic SHALL be sub-module hazard_fwd_unit, instantiated once per operand.

Verification
REQ-034 RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10; RdM=0 instead -> ForwardAE=01.
REQ-035 ResultSrcE=01, RdE=7, Rs2D=7 -> one cycle StallF=StallD=FlushE=1, next cycle with RdE=0 all 0.
REQ-036 Load-use plus PCSrcE=1 in the same cycle -> FlushD=FlushE=1, StallF=StallD=0.
REQ-037 MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> StallF..StallM=FlushW=1 for 3 cycles, 0 in cycle 4, state RUN in cycle 5.
REQ-038 MemReqM=1, MemReadyM=0 held 20 cycles, WAIT_W=4 -> TimeoutErr=1 from cycle 16 onward; n_rst pulse low -> TimeoutErr=0, stalls 0.
REQ-039 With HAZARD_PERF_CNT_EN, 4 memory-stall cycles and 2 redirects -> StallCnt=4, FlushCnt=2.
